// File: rtl/fir_coeff_pkg.sv
// rtl/fir_coeff_pkg.sv - shared encodings for the FIR coefficient loader
//
// Purpose: op codes, cmd_word field positions, FSM state enum and
//          status_out bit positions used by fir_coeff_loader.
// Ports:   none (package).
package fir_coeff_pkg;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_WRITE  = 2'b01,
      OP_COMMIT = 2'b10,
      OP_CLEAR  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      EXEC   = 3'd2,
      PEND   = 3'd3,
      CLEAR  = 3'd4
   } state_e;

   // cmd_word layout
   localparam int CMD_TOG_BIT   = 31;
   localparam int CMD_OP_MSB    = 30;
   localparam int CMD_OP_LSB    = 29;
   localparam int CMD_ADDR_MSB  = 28;
   localparam int CMD_ADDR_LSB  = 18;
   localparam int CMD_COEFF_MSB = 17;
   localparam int CMD_COEFF_LSB = 0;

   // status_out layout
   localparam int STAT_BUSY_BIT = 31;
   localparam int STAT_PEND_BIT = 30;
   localparam int STAT_BANK_BIT = 29;
   localparam int STAT_CNT_LSB  = 21;
   localparam int STAT_CNT_W    = 8;
   localparam int STAT_CSUM_LSB = 0;
   localparam int STAT_CSUM_W   = 16;

endpackage

// File: rtl/fir_coeff_bank_ram.sv
// rtl/fir_coeff_bank_ram.sv - two-bank coefficient RAM, simple dual port
//
// Purpose: 2*DEPTH x COEFF_W storage; the bank select is the address MSB.
// Ports:   clk_i       clock
//          rst_i       synchronous active-high reset (read register only)
//          wr_en_i     write enable
//          wr_addr_i   {bank, tap address}
//          wr_data_i   write data
//          rd_addr_i   {bank, tap address}
//          rd_data_o   registered read data, 1-cycle latency
module fir_coeff_bank_ram #(
   parameter int COEFF_W = 18,
   parameter int ADDR_W  = 11
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wr_en_i,
   input  logic [ADDR_W:0]    wr_addr_i,
   input  logic [COEFF_W-1:0] wr_data_i,
   input  logic [ADDR_W:0]    rd_addr_i,
   output logic [COEFF_W-1:0] rd_data_o
);

   localparam int WORDS = 2 * (2 ** ADDR_W);

   logic [COEFF_W-1:0] mem_q [0:WORDS-1];
   logic [COEFF_W-1:0] rd_data_q;

   // Contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fir_coeff_loader.sv
// rtl/fir_coeff_loader.sv - decodes FIR_load_coeff words into double-buffered tap writes
//
// Purpose: software writes taps into the shadow bank through a toggle-qualified
//          command word; a COMMIT swaps banks on the next sync_in frame pulse.
//          Optional macro FIR_COEFF_CHECKSUM_EN adds a 16-bit write checksum
//          on status_out[15:0] (reads 0 when undefined).
// Ports:   user_clk       clock
//          user_rst       synchronous active-high reset
//          cmd_word       [31] toggle, [30:29] op, [28:18] addr, [17:0] coeff
//          sync_in        frame-boundary pulse
//          coeff_rd_addr  FIR tap read address
//          coeff_rd_data  tap from active bank, 1-cycle latency
//          active_bank    bank read by the FIR
//          swap_pending   commit waiting for sync_in
//          busy           command in progress
//          status_out     {busy, swap_pending, active_bank, cmd_cnt, 5'b0, checksum}
module fir_coeff_loader
   import fir_coeff_pkg::*;
#(
   parameter int COEFF_W    = 18,
   parameter int ADDR_W     = 11,
   parameter int SETTLE_CYC = 2
) (
   input  logic               user_clk,
   input  logic               user_rst,
   input  logic [31:0]        cmd_word,
   input  logic               sync_in,
   input  logic [ADDR_W-1:0]  coeff_rd_addr,
   output logic [COEFF_W-1:0] coeff_rd_data,
   output logic               active_bank,
   output logic               swap_pending,
   output logic               busy,
   output logic [31:0]        status_out
);

   localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC);

   state_e              state_q, state_d;
   logic                tog_q, tog_d;
   logic [CNT_W-1:0]    settle_cnt_q, settle_cnt_d;
   op_e                 op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [COEFF_W-1:0]  coeff_q, coeff_d;
   logic [7:0]          cmd_cnt_q, cmd_cnt_d;
   logic                bank_q, bank_d;
   logic                pend_q, pend_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic                ram_we;
   logic [ADDR_W-1:0]   ram_waddr;
   logic [COEFF_W-1:0]  ram_wdata;
   logic [15:0]         csum;

   always_comb begin
      state_d      = state_q;
      tog_d        = tog_q;
      settle_cnt_d = settle_cnt_q;
      op_d         = op_q;
      addr_d       = addr_q;
      coeff_d      = coeff_q;
      cmd_cnt_d    = cmd_cnt_q;
      bank_d       = bank_q;
      pend_d       = pend_q;
      clr_addr_d   = clr_addr_q;
      ram_we       = 1'b0;
      ram_waddr    = addr_q;
      ram_wdata    = coeff_q;
      case (state_q)
         IDLE: begin
            // tog_q only moves when a word is latched, so edges arriving in
            // PEND/CLEAR stay visible here once the FSM returns.
            if (cmd_word[CMD_TOG_BIT] != tog_q) begin
               state_d      = SETTLE;
               settle_cnt_d = '0;
            end
         end
         SETTLE: begin
            if (settle_cnt_q == SETTLE_LAST) begin
               op_d      = op_e'(cmd_word[CMD_OP_MSB:CMD_OP_LSB]);
               addr_d    = cmd_word[CMD_ADDR_LSB +: ADDR_W];
               coeff_d   = cmd_word[CMD_COEFF_LSB +: COEFF_W];
               tog_d     = cmd_word[CMD_TOG_BIT];
               cmd_cnt_d = cmd_cnt_q + 8'd1;
               state_d   = EXEC;
            end else begin
               settle_cnt_d = settle_cnt_q + CNT_W'(1);
            end
         end
         EXEC: begin
            unique case (op_q)
               OP_NOP:    state_d = IDLE;
               OP_WRITE: begin
                  ram_we  = 1'b1;
                  state_d = IDLE;
               end
               OP_COMMIT: begin
                  pend_d  = 1'b1;
                  state_d = PEND;
               end
               OP_CLEAR: begin
                  clr_addr_d = '0;
                  state_d    = CLEAR;
               end
            endcase
         end
         PEND: begin
            if (sync_in) begin
               bank_d  = ~bank_q;
               pend_d  = 1'b0;
               state_d = IDLE;
            end
         end
         CLEAR: begin
            ram_we     = 1'b1;
            ram_waddr  = clr_addr_q;
            ram_wdata  = '0;
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == {ADDR_W{1'b1}}) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q      <= IDLE;
         tog_q        <= cmd_word[CMD_TOG_BIT];  // swallow any stale toggle
         settle_cnt_q <= '0;
         op_q         <= OP_NOP;
         addr_q       <= '0;
         coeff_q      <= '0;
         cmd_cnt_q    <= '0;
         bank_q       <= 1'b0;
         pend_q       <= 1'b0;
         clr_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         tog_q        <= tog_d;
         settle_cnt_q <= settle_cnt_d;
         op_q         <= op_d;
         addr_q       <= addr_d;
         coeff_q      <= coeff_d;
         cmd_cnt_q    <= cmd_cnt_d;
         bank_q       <= bank_d;
         pend_q       <= pend_d;
         clr_addr_q   <= clr_addr_d;
      end
   end

`ifdef FIR_COEFF_CHECKSUM_EN
   logic [15:0] csum_q, csum_d;

   always_comb begin
      csum_d = csum_q;
      if ((state_q == EXEC && op_q == OP_CLEAR) || (state_q == PEND && sync_in)) begin
         csum_d = '0;
      end else if (state_q == EXEC && op_q == OP_WRITE) begin
         csum_d = csum_q + 16'(coeff_q);
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign csum = csum_q;
`else
   assign csum = 16'h0;
`endif

   // Shadow is always the bank the FIR is not reading; reads use the
   // registered bank so a swap takes effect on the following read.
   fir_coeff_bank_ram #(
      .COEFF_W (COEFF_W),
      .ADDR_W  (ADDR_W)
   ) u_ram (
      .clk_i     (user_clk),
      .rst_i     (user_rst),
      .wr_en_i   (ram_we && !user_rst),
      .wr_addr_i ({~bank_q, ram_waddr}),
      .wr_data_i (ram_wdata),
      .rd_addr_i ({bank_q, coeff_rd_addr}),
      .rd_data_o (coeff_rd_data)
   );

   assign busy         = (state_q != IDLE);
   assign active_bank  = bank_q;
   assign swap_pending = pend_q;

   always_comb begin
      status_out                                 = '0;
      status_out[STAT_BUSY_BIT]                  = busy;
      status_out[STAT_PEND_BIT]                  = pend_q;
      status_out[STAT_BANK_BIT]                  = bank_q;
      status_out[STAT_CNT_LSB +: STAT_CNT_W]     = cmd_cnt_q;
      status_out[STAT_CSUM_LSB +: STAT_CSUM_W]   = csum;
   end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb/tb_fir_coeff_loader.sv - self-checking bench for fir_coeff_loader
module tb_fir_coeff_loader;

   localparam int COEFF_W    = 18;
   localparam int ADDR_W     = 11;
   localparam int SETTLE_CYC = 2;
   localparam int DEPTH      = 2 ** ADDR_W;

   localparam logic [1:0] C_NOP = 2'd0, C_WR = 2'd1, C_CM = 2'd2, C_CL = 2'd3;

`ifdef FIR_COEFF_CHECKSUM_EN
   localparam logic [15:0] CSUM_AFTER_1FFFF = 16'hFFFF;
`else
   localparam logic [15:0] CSUM_AFTER_1FFFF = 16'h0000;
`endif

   logic               user_clk = 1'b0;
   logic               user_rst;
   logic [31:0]        cmd_word;
   logic               sync_in;
   logic [ADDR_W-1:0]  coeff_rd_addr;
   logic [COEFF_W-1:0] coeff_rd_data;
   logic               active_bank;
   logic               swap_pending;
   logic               busy;
   logic [31:0]        status_out;

   always #5 user_clk = ~user_clk;

   fir_coeff_loader #(
      .COEFF_W    (COEFF_W),
      .ADDR_W     (ADDR_W),
      .SETTLE_CYC (SETTLE_CYC)
   ) dut (
      .user_clk      (user_clk),
      .user_rst      (user_rst),
      .cmd_word      (cmd_word),
      .sync_in       (sync_in),
      .coeff_rd_addr (coeff_rd_addr),
      .coeff_rd_data (coeff_rd_data),
      .active_bank   (active_bank),
      .swap_pending  (swap_pending),
      .busy          (busy),
      .status_out    (status_out)
   );

   int checks = 0;
   int errors = 0;

   // Behavioural model: visible register state after the most recent edge.
   logic               m_busy, m_pend, m_bank;
   logic [7:0]         m_cnt;
   logic [15:0]        m_csum;
   logic [COEFF_W-1:0] m_mem   [2][DEPTH];
   bit                 m_known [2][DEPTH];
   logic               tog;

   bit                 chk_en = 1'b0;
   bit                 exp_rd_ok = 1'b0;
   logic [COEFF_W-1:0] exp_rd;
   int                 busy_run = 0;
   int                 last_busy_run = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [15:0] c;
`ifdef FIR_COEFF_CHECKSUM_EN
      c = m_csum;
`else
      c = 16'h0;
`endif
      return {m_busy, m_pend, m_bank, m_cnt, 5'b0, c};
   endfunction

   always @(negedge user_clk) begin
      if (chk_en) begin
         if (exp_rd_ok) check("coeff_rd_data", 32'(coeff_rd_data), 32'(exp_rd));
         check("status_out", status_out, exp_status());
         check("ports busy/pend/bank", {29'b0, busy, swap_pending, active_bank},
               {29'b0, m_busy, m_pend, m_bank});
         if (busy) busy_run++;
         else begin
            if (busy_run != 0) last_busy_run = busy_run;
            busy_run = 0;
         end
      end
      // Data returned after the next edge comes from the bank in effect now.
      if (user_rst) begin
         exp_rd_ok = 1'b1;
         exp_rd    = '0;
      end else begin
         exp_rd_ok = m_known[m_bank][coeff_rd_addr];
         exp_rd    = m_mem[m_bank][coeff_rd_addr];
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge user_clk);
         #1;
      end
   endtask

   task automatic post_cmd(input logic [1:0] op, input logic [10:0] addr, input logic [17:0] coeff);
      tog      = ~tog;
      cmd_word = {tog, op, addr, coeff};
   endtask

   // Next edge is the one at which the loader first sees the toggle.
   task automatic run_cmd(input logic [1:0] op, input logic [10:0] addr, input logic [17:0] coeff,
                          input bit sync_at_exec, input int abort_at);
      logic sh;
      step(1);
      m_busy = 1'b1;
      step(SETTLE_CYC);
      step(1);
      m_cnt = m_cnt + 8'd1;
      sync_in = sync_at_exec;
      step(1);
      sync_in = 1'b0;
      sh = ~m_bank;
      case (op)
         C_NOP: m_busy = 1'b0;
         C_WR: begin
            m_mem[sh][addr]   = coeff;
            m_known[sh][addr] = 1'b1;
            m_csum            = m_csum + 16'(coeff);
            m_busy            = 1'b0;
         end
         C_CM: m_pend = 1'b1;
         default: begin
            m_csum = 16'h0;
            for (int i = 0; i < DEPTH; i++) begin
               if (i == abort_at) begin
                  m_known[sh][i] = 1'b0;
                  user_rst = 1'b1;
                  step(1);
                  user_rst = 1'b0;
                  m_busy = 1'b0;
                  m_pend = 1'b0;
                  m_bank = 1'b0;
                  m_cnt  = 8'd0;
                  m_csum = 16'h0;
                  return;
               end
               step(1);
               m_mem[sh][i]   = '0;
               m_known[sh][i] = 1'b1;
            end
            m_busy = 1'b0;
         end
      endcase
   endtask

   task automatic issue(input logic [1:0] op, input logic [10:0] addr, input logic [17:0] coeff,
                        input bit sync_at_exec, input int abort_at);
      post_cmd(op, addr, coeff);
      run_cmd(op, addr, coeff, sync_at_exec, abort_at);
   endtask

   task automatic do_sync();
      sync_in = 1'b1;
      step(1);
      sync_in = 1'b0;
      if (m_pend) begin
         m_bank = ~m_bank;
         m_pend = 1'b0;
         m_busy = 1'b0;
         m_csum = 16'h0;
      end
   endtask

   initial begin
      m_busy = 1'b0; m_pend = 1'b0; m_bank = 1'b0; m_cnt = 8'd0; m_csum = 16'h0;
      tog           = 1'b1;
      user_rst      = 1'b1;
      cmd_word      = 32'h8000_0000;
      sync_in       = 1'b0;
      coeff_rd_addr = '0;

      // 1: reset with toggle bit high must not decode a command
      step(1);
      chk_en = 1'b1;
      step(2);
      user_rst = 1'b0;
      step(6);
      check("t1 busy", 32'(busy), 32'd0);
      check("t1 status", status_out, 32'h0);

      // 2: write, commit, swap, read back
      issue(C_WR, 11'd5, 18'h1FFFF, 1'b0, -1);
      check("t2 checksum", 32'(status_out[15:0]), 32'(CSUM_AFTER_1FFFF));
      issue(C_CM, 11'd0, 18'd0, 1'b0, -1);
      coeff_rd_addr = 11'd5;
      step(2);
      check("t2 pending", 32'(swap_pending), 32'd1);
      do_sync();
      check("t2 active_bank", 32'(active_bank), 32'd1);
      step(1);
      check("t2 rd addr5", 32'(coeff_rd_data), 32'h1FFFF);

      // 4: sync during the commit EXEC cycle is ignored
      issue(C_CM, 11'd0, 18'd0, 1'b1, -1);
      check("t4 still pending", 32'(swap_pending), 32'd1);
      check("t4 bank unchanged", 32'(active_bank), 32'd1);
      step(3);
      do_sync();
      check("t4 swapped", 32'(active_bank), 32'd0);

      // 3: write toggled during PEND is deferred to after the swap
      issue(C_CM, 11'd0, 18'd0, 1'b0, -1);
      post_cmd(C_WR, 11'd7, 18'h00123);
      step(4);
      check("t3 cnt frozen", 32'(status_out[28:21]), 32'd4);
      do_sync();
      check("t3 pend dropped", 32'(swap_pending), 32'd0);
      check("t3 bank", 32'(active_bank), 32'd1);
      run_cmd(C_WR, 11'd7, 18'h00123, 1'b0, -1);
      check("t3 cnt", 32'(status_out[28:21]), 32'd5);
      issue(C_CM, 11'd0, 18'd0, 1'b0, -1);
      do_sync();
      coeff_rd_addr = 11'd7;
      step(2);
      check("t3 bank0 addr7", 32'(coeff_rd_data), 32'h123);

      // 5: clear shadow while FIR keeps reading the active bank
      issue(C_CL, 11'd0, 18'd0, 1'b0, -1);
      step(1);
      check("t5 busy cycles", 32'(last_busy_run), 32'(SETTLE_CYC + 2 + DEPTH));
      check("t5 active intact", 32'(coeff_rd_data), 32'h123);
      issue(C_CM, 11'd0, 18'd0, 1'b0, -1);
      do_sync();
      for (int i = 0; i < DEPTH; i++) begin
         coeff_rd_addr = ADDR_W'(i);
         step(1);
      end
      coeff_rd_addr = 11'd5;
      step(2);
      check("t5 cleared addr5", 32'(coeff_rd_data), 32'h0);

      // 6: reset in the middle of CLEAR, then a clean CLEAR
      issue(C_CL, 11'd0, 18'd0, 1'b0, 100);
      check("t6 status", status_out, 32'h0);
      check("t6 bank", 32'(active_bank), 32'd0);
      check("t6 rd_data", 32'(coeff_rd_data), 32'd0);
      step(2);
      issue(C_CL, 11'd0, 18'd0, 1'b0, -1);
      step(1);
      check("t6 busy cycles", 32'(last_busy_run), 32'(SETTLE_CYC + 2 + DEPTH));
      check("t6 cnt", 32'(status_out[28:21]), 32'd1);
      step(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
